// File: rtl/hv_encoder_ctrl_pkg.sv
// rtl/hv_encoder_ctrl_pkg.sv - shared types and constants for the HV encoder micro-sequencer
package hv_encoder_ctrl_pkg;

    localparam int INST_DEPTH     = 64;
    localparam int LOOP_CNT_WIDTH = 16;
    localparam int CTRL_WIDTH     = 38;
    localparam int INST_WIDTH     = CTRL_WIDTH + 2;
    localparam int PC_WIDTH       = $clog2(INST_DEPTH);

    typedef enum logic [1:0] {
        INST_EXEC = 2'b00,
        INST_LOOP = 2'b01,
        INST_END  = 2'b10,
        INST_HALT = 2'b11
    } inst_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Encoder fields occupy the low 35 bits; the top 3 bits are reserved padding.
    typedef struct packed {
        logic [2:0] rsvd;
        logic [1:0] alu_mux_a;
        logic [1:0] alu_mux_b;
        logic [1:0] alu_ops;
        logic [6:0] alu_shift_amt;
        logic [1:0] bund_mux_a;
        logic [1:0] bund_mux_b;
        logic       bund_valid_a;
        logic       bund_valid_b;
        logic       bund_clr_a;
        logic       bund_clr_b;
        logic [1:0] reg_mux;
        logic [1:0] reg_rd_addr_a;
        logic [1:0] reg_rd_addr_b;
        logic [1:0] reg_wr_addr;
        logic       reg_wr_en;
        logic       qhv_wen;
        logic       qhv_clr;
        logic [1:0] qhv_mux;
        logic       qhv_am_load;
    } ctrl_t;

    // Fields that change encoder state; cleared while the encoder is stalled so
    // that a held EXEC word commits its side effects exactly once, on release.
    localparam ctrl_t CTRL_SIDE_EFFECT_MASK = '{
        rsvd:          3'b000,
        alu_mux_a:     2'b00,
        alu_mux_b:     2'b00,
        alu_ops:       2'b00,
        alu_shift_amt: 7'b0000000,
        bund_mux_a:    2'b00,
        bund_mux_b:    2'b00,
        bund_valid_a:  1'b1,
        bund_valid_b:  1'b1,
        bund_clr_a:    1'b1,
        bund_clr_b:    1'b1,
        reg_mux:       2'b00,
        reg_rd_addr_a: 2'b00,
        reg_rd_addr_b: 2'b00,
        reg_wr_addr:   2'b00,
        reg_wr_en:     1'b1,
        qhv_wen:       1'b1,
        qhv_clr:       1'b1,
        qhv_mux:       2'b00,
        qhv_am_load:   1'b1
    };

endpackage

// File: rtl/hv_encoder_ctrl_imem.sv
// rtl/hv_encoder_ctrl_imem.sv - instruction store, one synchronous write port and one async read port
module hv_encoder_ctrl_imem
    import hv_encoder_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [PC_WIDTH-1:0]   wr_addr_i,
    input  logic [INST_WIDTH-1:0] wr_data_i,
    input  logic [PC_WIDTH-1:0]   rd_addr_i,
    output logic [INST_WIDTH-1:0] rd_data_o
);

    logic [INST_WIDTH-1:0] r_mem [INST_DEPTH];

    // Contents are deliberately left out of reset so a loaded program survives it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_addr_i];

endmodule

// File: rtl/hv_encoder_ctrl.sv
// rtl/hv_encoder_ctrl.sv - micro-sequencer driving encoder control words with one hardware loop level
module hv_encoder_ctrl
    import hv_encoder_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inst_wr_en_i,
    input  logic [PC_WIDTH-1:0]   inst_wr_addr_i,
    input  logic [INST_WIDTH-1:0] inst_wr_data_i,
    input  logic                  start_i,
    input  logic                  stall_i,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic                  global_stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [PC_WIDTH-1:0]   pc_o
);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [PC_WIDTH-1:0]       r_pc;
    logic [PC_WIDTH-1:0]       w_pc_nxt;
    logic [PC_WIDTH-1:0]       r_loop_start;
    logic [PC_WIDTH-1:0]       w_loop_start_nxt;
    logic [LOOP_CNT_WIDTH-1:0] r_loop_cnt;
    logic [LOOP_CNT_WIDTH-1:0] w_loop_cnt_nxt;
    logic [LOOP_CNT_WIDTH-1:0] w_loop_n;
    logic [INST_WIDTH-1:0]     w_inst;
    logic [CTRL_WIDTH-1:0]     w_payload;
    inst_type_e                w_inst_type;
    logic [CTRL_WIDTH-1:0]     w_ctrl;
    logic                      w_done;
    logic                      w_mem_wr_en;

    // Program writes only land while the sequencer is idle.
    assign w_mem_wr_en = inst_wr_en_i && (r_state == ST_IDLE);

    hv_encoder_ctrl_imem u_imem (
        .clk_i     (clk_i),
        .wr_en_i   (w_mem_wr_en),
        .wr_addr_i (inst_wr_addr_i),
        .wr_data_i (inst_wr_data_i),
        .rd_addr_i (r_pc),
        .rd_data_o (w_inst)
    );

    assign w_inst_type = inst_type_e'(w_inst[INST_WIDTH-1 -: 2]);
    assign w_payload   = w_inst[CTRL_WIDTH-1:0];
    assign w_loop_n    = w_inst[LOOP_CNT_WIDTH-1:0];

    // Next-state, pc/loop updates and the control word for the current instruction.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_loop_start_nxt = r_loop_start;
        w_loop_cnt_nxt   = r_loop_cnt;
        w_ctrl           = '0;
        w_done           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt      = ST_RUN;
                    w_pc_nxt         = '0;
                    w_loop_start_nxt = '0;
                    w_loop_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                case (w_inst_type)
                    INST_EXEC: begin
                        if (stall_i) begin
                            w_ctrl = w_payload & ~CTRL_SIDE_EFFECT_MASK;
                        end else begin
                            w_ctrl   = w_payload;
                            w_pc_nxt = r_pc + PC_WIDTH'(1);
                        end
                    end
                    INST_LOOP: begin
                        if (!stall_i) begin
                            w_loop_start_nxt = r_pc + PC_WIDTH'(1);
                            w_loop_cnt_nxt   = (w_loop_n == '0) ? LOOP_CNT_WIDTH'(1) : w_loop_n;
                            w_pc_nxt         = r_pc + PC_WIDTH'(1);
                        end
                    end
                    INST_END: begin
                        if (!stall_i) begin
                            if (r_loop_cnt > LOOP_CNT_WIDTH'(1)) begin
                                w_loop_cnt_nxt = r_loop_cnt - LOOP_CNT_WIDTH'(1);
                                w_pc_nxt       = r_loop_start;
                            end else begin
                                w_loop_cnt_nxt = '0;
                                w_pc_nxt       = r_pc + PC_WIDTH'(1);
                            end
                        end
                    end
                    INST_HALT: begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        endcase
    end

    // State, program counter and loop registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_loop_start <= '0;
            r_loop_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_loop_start <= w_loop_start_nxt;
            r_loop_cnt   <= w_loop_cnt_nxt;
        end
    end

    assign ctrl_o         = w_ctrl;
    assign done_o         = w_done;
    assign busy_o         = (r_state == ST_RUN);
    assign global_stall_o = stall_i && (r_state == ST_RUN);
    assign pc_o           = r_pc;

endmodule
